// File: rtl/secuenciador_alu_pkg.sv
// Shared constants for the ALU program sequencer: opcodes, ALU select codes and FSM states.
// Imported by the interface, the decoder and the top-level FSM.
package secuenciador_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LIT  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_JC   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS_ACC = 3'b000;
    localparam logic [2:0] ALU_SUB      = 3'b001;
    localparam logic [2:0] ALU_PASS_BUS = 3'b010;
    localparam logic [2:0] ALU_ADD      = 3'b011;
    localparam logic [2:0] ALU_NAND     = 3'b100;

    typedef logic [2:0] estado_t;

    localparam estado_t ST_IDLE  = 3'd0;
    localparam estado_t ST_FETCH = 3'd1;
    localparam estado_t ST_EXEC  = 3'd2;
    localparam estado_t ST_WRITE = 3'd3;
    localparam estado_t ST_HALT  = 3'd4;

    function automatic logic [3:0] opcode_of(input logic [7:0] ins);
        return ins[7:4];
    endfunction

endpackage

// File: rtl/secuenciador_alu_if.sv
// Bundle of program-memory, flag and datapath-control signals between the sequencer
// (master) and the memory/datapath side (slave).
interface secuenciador_alu_if #(
    parameter int PC_WIDTH = 4
);

    logic                start;
    logic [7:0]          instr;
    logic                c_alu;
    logic                z_alu;
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          operand;
    logic                control_1;
    logic                control_2;
    logic [2:0]          configuracion_alu;
    logic                enable_acumulador;
    logic                almacen;
    logic                busy;
    logic                done;

    modport master (
        input  start, instr, c_alu, z_alu,
        output pc, operand, control_1, control_2, configuracion_alu,
               enable_acumulador, almacen, busy, done
    );

    modport slave (
        output start, instr, c_alu, z_alu,
        input  pc, operand, control_1, control_2, configuracion_alu,
               enable_acumulador, almacen, busy, done
    );

endinterface

// File: rtl/secuenciador_alu_decodificador.sv
// Combinational opcode decoder: maps the IR opcode to ALU select, bus driver enables
// and the two sequencing hints (needs a WRITE cycle, is a branch).
module decodificador_instr
    import secuenciador_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [2:0] configuracion_alu_o,
    output logic       control_1_o,
    output logic       control_2_o,
    output logic       needs_write_o,
    output logic       is_branch_o
);

    always_comb begin
        configuracion_alu_o = ALU_PASS_ACC;
        control_1_o         = 1'b0;
        control_2_o         = 1'b0;
        needs_write_o       = 1'b0;
        is_branch_o         = 1'b0;
        case (opcode_i)
            OP_LIT: begin
                configuracion_alu_o = ALU_PASS_BUS;
                control_1_o         = 1'b1;
                needs_write_o       = 1'b1;
            end
            OP_ADD: begin
                configuracion_alu_o = ALU_ADD;
                control_1_o         = 1'b1;
                needs_write_o       = 1'b1;
            end
            OP_SUB: begin
                configuracion_alu_o = ALU_SUB;
                control_1_o         = 1'b1;
                needs_write_o       = 1'b1;
            end
            OP_NAND: begin
                configuracion_alu_o = ALU_NAND;
                control_1_o         = 1'b1;
                needs_write_o       = 1'b1;
            end
            OP_OUT: begin
                configuracion_alu_o = ALU_PASS_ACC;
                control_2_o         = 1'b1;
            end
            OP_JZ, OP_JC, OP_JMP: is_branch_o = 1'b1;
            // NOP, HALT and the undefined opcodes 9-E assert nothing here.
            OP_NOP, OP_HALT: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/secuenciador_alu.sv
// Program sequencer for the 4-bit ALU/accumulator datapath: FETCH/EXEC/WRITE FSM,
// program counter, instruction register and busy/done status.
module secuenciador_alu
    import secuenciador_pkg::*;
#(
    parameter int PC_WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    secuenciador_alu_if.master bus
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic                rst_sync_q;
    estado_t             state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [3:0]          op_ir;
    logic [2:0]          dec_cfg;
    logic                dec_c1, dec_c2, dec_wr, dec_br;
    logic                take_branch;
    logic                in_exec, in_write, active;

    // Branch targets are the 4-bit immediate, zero-extended or truncated to the PC width.
    function automatic logic [PC_WIDTH-1:0] jump_target(input logic [3:0] imm);
        logic [PC_WIDTH-1:0] t;
        t = '0;
        for (int i = 0; i < PC_WIDTH && i < 4; i++) t[i] = imm[i];
        return t;
    endfunction

    // Assertion is immediate; release reaches the FSM one clock later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 1'b0;
        else        rst_sync_q <= 1'b1;
    end

    assign op_ir = opcode_of(ir_q);

    decodificador_instr u_dec (
        .opcode_i            (op_ir),
        .configuracion_alu_o (dec_cfg),
        .control_1_o         (dec_c1),
        .control_2_o         (dec_c2),
        .needs_write_o       (dec_wr),
        .is_branch_o         (dec_br)
    );

    always_comb begin
        take_branch = 1'b0;
        if (dec_br) begin
            case (op_ir)
                OP_JZ:   take_branch = bus.z_alu;
                OP_JC:   take_branch = bus.c_alu;
                default: take_branch = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = bus.instr;
                state_d = ST_EXEC;
                // Status flips as HALT enters the IR so done is visible during its EXEC cycle.
                if (opcode_of(bus.instr) == OP_HALT) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (dec_wr) begin
                    state_d = ST_WRITE;
                end else if (op_ir == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = take_branch ? jump_target(ir_q[3:0]) : pc_q + PC_ONE;
                end
            end
            ST_WRITE: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + PC_ONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Controls come only from registered state and IR, and are forced low outside EXEC/WRITE.
    assign in_exec  = (state_q == ST_EXEC);
    assign in_write = (state_q == ST_WRITE);
    assign active   = in_exec | in_write;

    assign bus.control_1         = active & dec_c1;
    assign bus.control_2         = in_exec & dec_c2;
    assign bus.configuracion_alu = active ? dec_cfg : 3'b000;
    assign bus.operand           = (active & dec_c1) ? ir_q[3:0] : 4'd0;
    assign bus.enable_acumulador = in_write | (in_exec & dec_c2);
    assign bus.almacen           = in_write;
    assign bus.pc                = pc_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;

endmodule
